refresh_scheduler: RTL and testbench
====================================

// Module: refresh_scheduler
// PURPOSE
//  Parametrised DDR3 refresh scheduler replacing the free-running refresh counter at the top level.
//  Issues one tREFI tick per interval and keeps a debt of postponed refreshes.
//  Requests REF opportunistically when the controller is idle, or urgently once the debt builds up.
//  Holds a tRFC busy window after each granted refresh. Sits between the clk domain counter logic and the main DRAM state machine's REF input.
// PARAMETERS
//  CNT_W          32    width of interval counter and trefi_cfg
//  TREFI_CYCLES   2496  default refresh interval in clk cycles (7.8 us @ 320 MHz)
//  TRFC_CYCLES    52    busy window after REF issue (160 ns @ 320 MHz), >=1
//  MAX_DEBT       8     max postponed refreshes (JEDEC limit), >=2
//  URGENT_THRESH  6     debt at/above which request ignores idle, 1..MAX_DEBT
//  DEBT_W         $clog2(MAX_DEBT+1)  derived, width of debt
// PORTS
//  clk           in   1       controller clock (320 MHz)
//  rst_n         in   1       asynchronous active-low reset
//  enable        in   1       1 = interval counter runs; 0 = counter held at 0, no new ticks
//  ctrl_idle     in   1       main SM in IDLE with no pending read/write
//  trefi_cfg     in   CNT_W   runtime interval; 0 = use TREFI_CYCLES; sampled only at wrap/enable rise
//  ref_ack       in   1       one-cycle pulse: controller issued REF command this cycle
//  ref_req       out  1       refresh request, held until ref_ack
//  ref_urgent    out  1       debt >= URGENT_THRESH
//  ref_busy      out  1       tRFC window active; controller must not issue ACT/REF
//  debt          out  DEBT_W  outstanding refreshes owed
//  err_overflow  out  1       sticky: tick arrived while debt==MAX_DEBT and no ack
//  err_spurious  out  1       sticky: ref_ack seen outside S_REQ
// BEHAVIOUR
//  Reset (rst_n=0, async): all outputs 0, interval counter 0, active interval = TREFI_CYCLES, FSM S_IDLE.
//  Interval: active_int = (trefi_cfg==0) ? TREFI_CYCLES : trefi_cfg, latched at reset release, enable rise, each wrap.
//  - enable=1: cnt increments each cycle; at cnt==active_int-1, tick=1 and cnt<=0.
//  - enable=0: cnt<=0, tick=0.
//  - debt, FSM and busy timer are unaffected by enable.
//  Debt update (same edge as tick/ack):
//  - tick&!ack: debt+1, saturates at MAX_DEBT.
//  - !tick&ack: debt-1.
//  - tick&ack: debt unchanged.
//  - tick&!ack with debt==MAX_DEBT: debt stays, err_overflow<=1.
//  ref_urgent registered: 1 iff debt >= URGENT_THRESH.
//  FSM states S_IDLE, S_REQ, S_TRFC. All outputs are registered.
//  S_IDLE -> S_REQ when debt>=1 and (ctrl_idle or debt>=URGENT_THRESH).
//  - ref_req=1 from the cycle after entry condition is seen.
//  S_REQ: ref_req=1, no withdrawal even if ctrl_idle drops. On ref_ack -> S_TRFC, ref_req=0 next cycle, debt-1.
//  S_TRFC: ref_busy=1 for exactly TRFC_CYCLES cycles starting the cycle after ack, then S_IDLE.
//  - Back-to-back: S_IDLE may re-enter S_REQ on the first cycle after busy drops.
//  ref_ack in S_IDLE or S_TRFC: ignored (no debt change), err_spurious<=1.
//  Errors clear only on reset. Async reset mid-S_REQ/S_TRFC aborts to S_IDLE with debt 0.
//  Latency: tick edge -> debt=1 -> ref_req high one edge later (2 cycles from tick edge) if ctrl_idle=1.
// TESTING (TREFI_CYCLES=200, TRFC_CYCLES=4, MAX_DEBT=8, URGENT_THRESH=6, trefi_cfg=0)
//  1. enable=1, ctrl_idle=1, ack 3 cycles after req -> tick every 200 cycles; req 2 cycles after tick; busy high exactly 4 cycles; debt 1->0.
//  2. ctrl_idle=0, no ack, 6 intervals -> debt counts 1..6; ref_urgent and ref_req rise after 6th tick; ack -> debt 5, busy 4 cycles, req reasserts (debt 5 < 6 but... idle=0 so stays low) -> req low.
//  3. ctrl_idle=0, no ack, 9 intervals -> debt saturates at 8, err_overflow=1 after 9th tick and stays 1.
//  4. Ack on same edge as tick with debt=3 in S_REQ -> debt stays 3; S_TRFC entered.
//  5. ref_ack pulse in S_IDLE and during busy -> debt unchanged, err_spurious=1; trefi_cfg=50 written mid-interval -> current interval still 200, next interval 50.
//  6. rst_n low during S_TRFC with debt=4 -> all outputs 0 immediately; enable=0 for 500 cycles -> no ticks, debt 0.

Source files
------------

// File: rtl/refresh_scheduler_if.sv
// Refresh handshake bundle between the refresh scheduler and the main DRAM
// state machine.
//   ctrl_idle     controller idle, no pending read/write
//   ref_ack       one-cycle pulse: REF command issued this cycle
//   ref_req       refresh request, held until ref_ack
//   ref_urgent    postponed-refresh debt at/above urgent threshold
//   ref_busy      tRFC window active, no ACT/REF allowed
//   debt          outstanding refreshes owed
//   err_overflow  sticky: tick lost at maximum debt
//   err_spurious  sticky: ref_ack seen while no request outstanding
// slave = scheduler side, master = controller side.
interface refresh_scheduler_if #(
  parameter int DEBT_W = 4
);
  logic              ctrl_idle;
  logic              ref_ack;
  logic              ref_req;
  logic              ref_urgent;
  logic              ref_busy;
  logic [DEBT_W-1:0] debt;
  logic              err_overflow;
  logic              err_spurious;

  modport slave (
    input  ctrl_idle, ref_ack,
    output ref_req, ref_urgent, ref_busy, debt, err_overflow, err_spurious
  );

  modport master (
    output ctrl_idle, ref_ack,
    input  ref_req, ref_urgent, ref_busy, debt, err_overflow, err_spurious
  );
endinterface

// File: rtl/refresh_scheduler.sv
// DDR3 refresh scheduler. Generates one tREFI tick per interval, tracks the
// debt of postponed refreshes, requests REF when the controller is idle or
// when the debt becomes urgent, and holds a tRFC busy window after each REF.
//   clk        controller clock
//   rst_n      asynchronous active-low reset
//   enable     1 = interval counter runs, 0 = counter held at 0
//   trefi_cfg  runtime interval (0 = TREFI_CYCLES), taken at wrap/enable rise
//   rif        refresh handshake bundle (slave side)
//
// state   | meaning
// S_IDLE  | no request outstanding, waiting for debt and an opportunity
// S_REQ   | ref_req held high until the controller acks
// S_TRFC  | ref_busy high for TRFC_CYCLES cycles after the ack
module refresh_scheduler #(
  parameter int CNT_W         = 32,
  parameter int TREFI_CYCLES  = 2496,
  parameter int TRFC_CYCLES   = 52,
  parameter int MAX_DEBT      = 8,
  parameter int URGENT_THRESH = 6,
  localparam int DEBT_W       = $clog2(MAX_DEBT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [CNT_W-1:0]     trefi_cfg,
  refresh_scheduler_if.slave   rif
);
  localparam int TMR_W = (TRFC_CYCLES > 1) ? $clog2(TRFC_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_TRFC = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  active_int_q, active_int_d;
  logic              init_q, enable_q;
  logic [DEBT_W-1:0] debt_q, debt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              urgent_q, urgent_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic              spur_q, spur_d;

  logic [CNT_W-1:0]  int_sel, int_use;
  logic              load, tick, ack_ok;

  always_comb begin
    int_sel      = (trefi_cfg == '0) ? CNT_W'(TREFI_CYCLES) : trefi_cfg;
    // First cycle out of reset and every enable rise pick up a fresh interval;
    // the compare uses it immediately so the first interval is full length.
    load         = !init_q || (enable && !enable_q);
    int_use      = load ? int_sel : active_int_q;
    active_int_d = int_use;
    cnt_d        = cnt_q;
    tick         = 1'b0;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == int_use - CNT_W'(1)) begin
      tick         = 1'b1;
      cnt_d        = '0;
      active_int_d = int_sel;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    ack_ok = rif.ref_ack && (state_q == S_REQ);
    debt_d = debt_q;
    ovf_d  = ovf_q;
    spur_d = spur_q || (rif.ref_ack && (state_q != S_REQ));
    if (tick && !ack_ok) begin
      if (debt_q == DEBT_W'(MAX_DEBT)) ovf_d = 1'b1;
      else                             debt_d = debt_q + DEBT_W'(1);
    end else if (!tick && ack_ok) begin
      debt_d = debt_q - DEBT_W'(1);
    end

    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      S_IDLE: begin
        if ((debt_q != '0) &&
            (rif.ctrl_idle || (debt_q >= DEBT_W'(URGENT_THRESH))))
          state_d = S_REQ;
      end
      S_REQ: begin
        if (rif.ref_ack) begin
          state_d = S_TRFC;
          tmr_d   = TMR_W'(TRFC_CYCLES - 1);
        end
      end
      S_TRFC: begin
        if (tmr_q == '0) state_d = S_IDLE;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    req_d    = (state_d == S_REQ);
    busy_d   = (state_d == S_TRFC);
    urgent_d = (debt_d >= DEBT_W'(URGENT_THRESH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      active_int_q <= CNT_W'(TREFI_CYCLES);
      init_q       <= 1'b0;
      enable_q     <= 1'b0;
      debt_q       <= '0;
      tmr_q        <= '0;
      urgent_q     <= 1'b0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
      spur_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      active_int_q <= active_int_d;
      init_q       <= 1'b1;
      enable_q     <= enable;
      debt_q       <= debt_d;
      tmr_q        <= tmr_d;
      urgent_q     <= urgent_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      ovf_q        <= ovf_d;
      spur_q       <= spur_d;
    end
  end

  assign rif.ref_req      = req_q;
  assign rif.ref_urgent   = urgent_q;
  assign rif.ref_busy     = busy_q;
  assign rif.debt         = debt_q;
  assign rif.err_overflow = ovf_q;
  assign rif.err_spurious = spur_q;
endmodule

// File: tb/tb_refresh_scheduler.sv
module tb_refresh_scheduler;
  localparam int TREFI = 200;
  localparam int TRFC  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] trefi_cfg = '0;

  refresh_scheduler_if #(.DEBT_W(4)) rif ();

  refresh_scheduler #(
    .CNT_W(32), .TREFI_CYCLES(TREFI), .TRFC_CYCLES(TRFC),
    .MAX_DEBT(8), .URGENT_THRESH(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .trefi_cfg(trefi_cfg), .rif(rif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rel = 0;
  int n_tests = 0;
  int n_fail = 0;
  int exp_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic en, input logic idle);
    rst_n = 1'b0;
    rif.ref_ack = 1'b0;
    rif.ctrl_idle = idle;
    enable = en;
    trefi_cfg = '0;
    step();
    step();
    rst_n = 1'b1;
    rel = cyc;
  endtask

  task automatic wait_to(input int t);
    while (cyc - rel < t) step();
  endtask

  task automatic wait_debt(input int val, input int bound, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (int'(rif.debt) == val) begin
        ok = 1'b1;
        at = cyc - rel;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rif.ref_ack = 1'b0;
    rif.ctrl_idle = 1'b1;
    enable = 1'b1;
    step();
    step();
    n_tests++;
    if ({rif.ref_req, rif.ref_urgent, rif.ref_busy, rif.err_overflow, rif.err_spurious} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {rif.ref_req, rif.ref_urgent, rif.ref_busy, rif.err_overflow, rif.err_spurious});
    end
    n_tests++;
    if (rif.debt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_debt: got %0d expected 0", rif.debt);
    end
  endtask

  task automatic test_basic();
    int at, e, nb;
    bit ok;
    do_reset(1'b1, 1'b1);
    exp_q.push_back(TREFI);
    exp_q.push_back(2 * TREFI);
    wait_debt(1, 300, at, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || at != e) begin
      n_fail++;
      $display("FAIL basic_tick1: got cycle %0d expected %0d", at, e);
    end
    step();
    n_tests++;
    if (rif.ref_req !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_req_latency: got %b expected 1", rif.ref_req);
    end
    repeat (3) step();
    rif.ref_ack = 1'b1;
    step();
    rif.ref_ack = 1'b0;
    n_tests++;
    if ({rif.ref_req, rif.ref_busy, rif.debt} !== {1'b0, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL basic_after_ack: got req=%b busy=%b debt=%0d expected req=0 busy=1 debt=0",
               rif.ref_req, rif.ref_busy, rif.debt);
    end
    nb = 0;
    while (rif.ref_busy && nb < 20) begin
      nb++;
      step();
    end
    n_tests++;
    if (nb != TRFC) begin
      n_fail++;
      $display("FAIL basic_busy_len: got %0d expected %0d", nb, TRFC);
    end
    wait_debt(1, 300, at, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || at != e) begin
      n_fail++;
      $display("FAIL basic_tick2: got cycle %0d expected %0d", at, e);
    end
  endtask

  task automatic test_debt_urgent();
    int at, e, nb;
    bit ok, seen;
    do_reset(1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) exp_q.push_back(TREFI * i);
    for (int i = 1; i <= 6; i++) begin
      wait_debt(i, 300, at, ok);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || at != e) begin
        n_fail++;
        $display("FAIL debt_tick%0d: got cycle %0d expected %0d", i, at, e);
      end
      n_tests++;
      if (rif.ref_urgent !== (i >= 6)) begin
        n_fail++;
        $display("FAIL debt_urgent%0d: got %b expected %b", i, rif.ref_urgent, (i >= 6));
      end
      step();
      n_tests++;
      if (rif.ref_req !== (i >= 6)) begin
        n_fail++;
        $display("FAIL debt_req%0d: got %b expected %b", i, rif.ref_req, (i >= 6));
      end
    end
    step();
    rif.ref_ack = 1'b1;
    step();
    rif.ref_ack = 1'b0;
    n_tests++;
    if ({rif.debt, rif.ref_busy, rif.ref_urgent, rif.ref_req} !== {4'd5, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL debt_after_ack: got debt=%0d busy=%b urgent=%b req=%b expected 5 1 0 0",
               rif.debt, rif.ref_busy, rif.ref_urgent, rif.ref_req);
    end
    nb = 0;
    while (rif.ref_busy && nb < 20) begin
      nb++;
      step();
    end
    n_tests++;
    if (nb != TRFC) begin
      n_fail++;
      $display("FAIL debt_busy_len: got %0d expected %0d", nb, TRFC);
    end
    seen = 1'b0;
    repeat (6) begin
      if (rif.ref_req) seen = 1'b1;
      step();
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL debt_no_rereq: got req seen=%b expected 0", seen);
    end
  endtask

  task automatic test_overflow();
    do_reset(1'b1, 1'b0);
    wait_to(8 * TREFI);
    n_tests++;
    if ({rif.debt, rif.err_overflow} !== {4'd8, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_at8: got debt=%0d ovf=%b expected 8 0", rif.debt, rif.err_overflow);
    end
    wait_to(9 * TREFI - 1);
    n_tests++;
    if (rif.err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_early: got %b expected 0", rif.err_overflow);
    end
    wait_to(9 * TREFI);
    n_tests++;
    if ({rif.debt, rif.err_overflow} !== {4'd8, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_at9: got debt=%0d ovf=%b expected 8 1", rif.debt, rif.err_overflow);
    end
    wait_to(10 * TREFI + 50);
    n_tests++;
    if ({rif.debt, rif.err_overflow, rif.ref_req, rif.ref_urgent} !== {4'd8, 1'b1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_sticky: got debt=%0d ovf=%b req=%b urgent=%b expected 8 1 1 1",
               rif.debt, rif.err_overflow, rif.ref_req, rif.ref_urgent);
    end
  endtask

  task automatic test_ack_on_tick();
    int nb, g;
    do_reset(1'b1, 1'b0);
    wait_to(3 * TREFI);
    n_tests++;
    if (rif.debt !== 4'd3) begin
      n_fail++;
      $display("FAIL tickack_pre_debt: got %0d expected 3", rif.debt);
    end
    rif.ctrl_idle = 1'b1;
    step();
    n_tests++;
    if (rif.ref_req !== 1'b1) begin
      n_fail++;
      $display("FAIL tickack_req: got %b expected 1", rif.ref_req);
    end
    wait_to(4 * TREFI - 1);
    rif.ref_ack = 1'b1;
    step();
    rif.ref_ack = 1'b0;
    n_tests++;
    if ({rif.debt, rif.ref_busy, rif.ref_req, rif.err_spurious} !== {4'd3, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL tickack_same_edge: got debt=%0d busy=%b req=%b spur=%b expected 3 1 0 0",
               rif.debt, rif.ref_busy, rif.ref_req, rif.err_spurious);
    end
    nb = 0;
    while (rif.ref_busy && nb < 20) begin
      nb++;
      step();
    end
    g = 0;
    while (!rif.ref_req && g < 10) begin
      g++;
      step();
    end
    n_tests++;
    if (g != 1) begin
      n_fail++;
      $display("FAIL back_to_back_gap: got %0d cycles expected 1", g);
    end
  endtask

  task automatic test_spurious();
    int at, e;
    bit ok;
    do_reset(1'b1, 1'b1);
    wait_debt(1, 300, at, ok);
    step();
    rif.ref_ack = 1'b1;
    step();
    rif.ref_ack = 1'b0;
    n_tests++;
    if ({rif.err_spurious, rif.ref_busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL spur_legit_ack: got spur=%b busy=%b expected 0 1", rif.err_spurious, rif.ref_busy);
    end
    rif.ref_ack = 1'b1;
    step();
    rif.ref_ack = 1'b0;
    n_tests++;
    if ({rif.debt, rif.err_spurious} !== {4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL spur_in_busy: got debt=%0d spur=%b expected 0 1", rif.debt, rif.err_spurious);
    end

    do_reset(1'b1, 1'b0);
    wait_to(TREFI + 5);
    rif.ref_ack = 1'b1;
    step();
    rif.ref_ack = 1'b0;
    n_tests++;
    if ({rif.debt, rif.err_spurious} !== {4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL spur_in_idle: got debt=%0d spur=%b expected 1 1", rif.debt, rif.err_spurious);
    end
    wait_to(TREFI + 100);
    trefi_cfg = 32'd50;
    exp_q.push_back(2 * TREFI);
    exp_q.push_back(2 * TREFI + 50);
    exp_q.push_back(2 * TREFI + 100);
    for (int v = 2; v <= 4; v++) begin
      wait_debt(v, 300, at, ok);
      e = exp_q.pop_front();
      n_tests++;
      if (!ok || at != e) begin
        n_fail++;
        $display("FAIL cfg_tick_debt%0d: got cycle %0d expected %0d", v, at, e);
      end
    end
    trefi_cfg = '0;
  endtask

  task automatic test_reset_abort();
    int at, e, changes;
    bit ok;
    do_reset(1'b1, 1'b0);
    wait_to(5 * TREFI);
    rif.ctrl_idle = 1'b1;
    step();
    rif.ref_ack = 1'b1;
    step();
    rif.ref_ack = 1'b0;
    n_tests++;
    if ({rif.debt, rif.ref_busy} !== {4'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_pre: got debt=%0d busy=%b expected 4 1", rif.debt, rif.ref_busy);
    end
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({rif.ref_req, rif.ref_urgent, rif.ref_busy, rif.debt, rif.err_overflow, rif.err_spurious} !== 9'b0) begin
      n_fail++;
      $display("FAIL abort_async: got %b expected all zero",
               {rif.ref_req, rif.ref_urgent, rif.ref_busy, rif.debt, rif.err_overflow, rif.err_spurious});
    end
    step();
    step();
    enable = 1'b0;
    rst_n = 1'b1;
    changes = 0;
    repeat (500) begin
      step();
      if (rif.debt !== 4'd0 || rif.ref_req !== 1'b0) changes++;
    end
    n_tests++;
    if (changes != 0) begin
      n_fail++;
      $display("FAIL disabled_no_tick: got %0d active cycles expected 0", changes);
    end
    rel = cyc;
    enable = 1'b1;
    exp_q.push_back(TREFI);
    wait_debt(1, 300, at, ok);
    e = exp_q.pop_front();
    n_tests++;
    if (!ok || at != e) begin
      n_fail++;
      $display("FAIL enable_rise_tick: got cycle %0d expected %0d", at, e);
    end
  endtask

  initial begin
    rif.ref_ack = 1'b0;
    rif.ctrl_idle = 1'b0;
    test_reset();
    test_basic();
    test_debt_urgent();
    test_overflow();
    test_ack_on_tick();
    test_spurious();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
